// File: rtl/l1d_mshr_entry_merge.sv
// L1D MSHR entry: owns one missing line through hazard wait, evict, clean,
// multi-beat linefill and in-order replay of a merge queue of same-line requests.
module l1d_mshr_entry_merge #(
  parameter int ENTRY_NUM = 8,
  parameter int INDEX_W   = 6,
  parameter int TAG_W     = 20,
  parameter int WAY_W     = 2,
  parameter int OFFSET_W  = 4,
  parameter int DATA_W    = 64,
  parameter int SUB_NUM   = 4,
  parameter int BEATS     = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int UPD_W = INDEX_W + WAY_W + 2 * TAG_W + 4 + OFFSET_W + DATA_W + BE_W + 2 * ENTRY_NUM,
  localparam int MRG_W = 1 + OFFSET_W + DATA_W + BE_W,
  localparam int DAT_W = 1 + INDEX_W + WAY_W + OFFSET_W + DATA_W + BE_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         alloc_vld,
  input  logic                         alloc_en,
  input  logic                         upd_en,
  input  logic [UPD_W-1:0]             upd_pld,
  input  logic                         merge_vld,
  output logic                         merge_rdy,
  input  logic [MRG_W-1:0]             merge_pld,
  input  logic [ENTRY_NUM-1:0]         v_release_iw_in,
  input  logic [ENTRY_NUM-1:0]         v_release_et_in,
  output logic                         evict_req_vld,
  input  logic                         evict_req_rdy,
  output logic [INDEX_W+WAY_W-1:0]     evict_req_pld,
  input  logic                         evict_dat_ram_clean_en,
  input  logic                         evict_done_en,
  output logic                         downstream_req_vld,
  input  logic                         downstream_req_rdy,
  output logic [INDEX_W+WAY_W+TAG_W-1:0] downstream_req_pld,
  input  logic                         linefill_beat_en,
  output logic                         dat_ram_req_vld,
  input  logic                         dat_ram_req_rdy,
  output logic [DAT_W-1:0]             dat_ram_req_pld,
  output logic [INDEX_W-1:0]           hzd_index,
  output logic [WAY_W-1:0]             hzd_way,
  output logic [TAG_W-1:0]             hzd_evict_tag,
  output logic                         hzd_iw_en,
  output logic                         hzd_et_en,
  output logic                         release_iw_en,
  output logic                         release_et_en
);

  localparam int PTR_W  = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1;
  localparam int CNT_W  = $clog2(SUB_NUM + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALLOC   = 3'd1,
    S_HZD     = 3'd2,
    S_EVICT   = 3'd3,
    S_CLEAN   = 3'd4,
    S_LF_REQ  = 3'd5,
    S_LF_WAIT = 3'd6,
    S_REPLAY  = 3'd7
  } state_t;

  typedef struct packed {
    logic [INDEX_W-1:0]   index;
    logic [WAY_W-1:0]     way;
    logic [TAG_W-1:0]     new_tag;
    logic [TAG_W-1:0]     evict_tag;
    logic                 need_evict;
    logic                 need_linefill;
    logic                 need_rw;
    logic                 rw;
    logic [OFFSET_W-1:0]  offset;
    logic [DATA_W-1:0]    wdata;
    logic [BE_W-1:0]      be;
    logic [ENTRY_NUM-1:0] hzd_iw_line;
    logic [ENTRY_NUM-1:0] hzd_et_line;
  } upd_t;

  typedef struct packed {
    logic                rw;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     be;
  } req_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(SUB_NUM - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t               state_r;
  logic [INDEX_W-1:0]   index_r;
  logic [WAY_W-1:0]     way_r;
  logic [TAG_W-1:0]     new_tag_r;
  logic [TAG_W-1:0]     evict_tag_r;
  logic                 need_evict_r;
  logic                 need_linefill_r;
  logic                 evict_pend_r;
  logic [ENTRY_NUM-1:0] iw_line_r;
  logic [ENTRY_NUM-1:0] et_line_r;
  logic [BEAT_W-1:0]    beat_cnt_r;
  logic                 release_iw_r;
  logic                 release_et_r;
  logic [MRG_W-1:0]     q_mem_r [SUB_NUM];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     cnt_r;

  upd_t                 upd_s;
  req_t                 head_s;
  logic [ENTRY_NUM-1:0] iw_next_s;
  logic [ENTRY_NUM-1:0] et_next_s;
  logic                 free_s;
  logic                 alloc_upd_s;
  logic                 merge_state_s;
  logic                 merge_push_s;
  logic                 upd_push_s;
  logic                 push_s;
  logic [MRG_W-1:0]     push_data_s;
  logic                 pop_s;
  logic                 pend_clear_s;
  logic                 replay_exit_s;

  assign upd_s  = upd_t'(upd_pld);
  assign head_s = req_t'(q_mem_r[rd_ptr_r]);

  // Hazard is judged on the line value after this cycle's release pulses.
  assign iw_next_s = iw_line_r & ~v_release_iw_in;
  assign et_next_s = et_line_r & ~v_release_et_in;
  assign free_s    = ~|{iw_next_s, et_next_s};

  assign alloc_upd_s   = (state_r == S_ALLOC) && upd_en;
  assign merge_state_s = (state_r == S_HZD) || (state_r == S_EVICT) || (state_r == S_CLEAN) ||
                         (state_r == S_LF_REQ) || (state_r == S_LF_WAIT);
  assign merge_rdy     = merge_state_s && (cnt_r < CNT_W'(SUB_NUM));
  assign merge_push_s  = merge_vld && merge_rdy;
  assign upd_push_s    = alloc_upd_s && upd_s.need_rw;
  assign push_s        = merge_push_s || upd_push_s;

  // Select the enqueue source: the primary request or a secondary merge.
  always_comb begin
    push_data_s = merge_pld;
    if (upd_push_s) begin
      push_data_s = {upd_s.rw, upd_s.offset, upd_s.wdata, upd_s.be};
    end else begin
      push_data_s = merge_pld;
    end
  end

  assign alloc_vld          = (state_r == S_IDLE);
  assign evict_req_vld      = (state_r == S_EVICT);
  assign downstream_req_vld = (state_r == S_LF_REQ);
  assign dat_ram_req_vld    = (state_r == S_REPLAY) && (cnt_r != '0);
  assign pop_s              = dat_ram_req_vld && dat_ram_req_rdy;
  assign pend_clear_s       = ~evict_pend_r || evict_done_en;
  assign replay_exit_s      = (state_r == S_REPLAY) &&
                              (((cnt_r == '0) && ~evict_pend_r) ||
                               (pop_s && (cnt_r == CNT_W'(1)) && pend_clear_s));

  assign evict_req_pld      = {index_r, way_r};
  assign downstream_req_pld = {index_r, way_r, new_tag_r};
  assign dat_ram_req_pld    = dat_ram_req_vld ?
                              {head_s.rw, index_r, way_r, head_s.offset, head_s.wdata, head_s.be, ~&head_s.be} :
                              '0;

  assign hzd_index     = index_r;
  assign hzd_way       = way_r;
  assign hzd_evict_tag = evict_tag_r;
  assign hzd_iw_en     = (state_r != S_IDLE) && (state_r != S_ALLOC);
  assign hzd_et_en     = evict_pend_r;
  assign release_iw_en = release_iw_r;
  assign release_et_en = release_et_r;

  // Entry sequencer, line identity, hazard lines and release pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_IDLE;
      index_r         <= '0;
      way_r           <= '0;
      new_tag_r       <= '0;
      evict_tag_r     <= '0;
      need_evict_r    <= 1'b0;
      need_linefill_r <= 1'b0;
      evict_pend_r    <= 1'b0;
      iw_line_r       <= '0;
      et_line_r       <= '0;
      beat_cnt_r      <= '0;
      release_iw_r    <= 1'b0;
      release_et_r    <= 1'b0;
    end else begin
      release_iw_r <= replay_exit_s;
      release_et_r <= evict_pend_r && evict_done_en && !alloc_upd_s;
      if (alloc_upd_s) begin
        index_r         <= upd_s.index;
        way_r           <= upd_s.way;
        new_tag_r       <= upd_s.new_tag;
        evict_tag_r     <= upd_s.evict_tag;
        need_evict_r    <= upd_s.need_evict;
        need_linefill_r <= upd_s.need_linefill;
        evict_pend_r    <= upd_s.need_evict;
        iw_line_r       <= upd_s.hzd_iw_line;
        et_line_r       <= upd_s.hzd_et_line;
      end else begin
        iw_line_r <= iw_next_s;
        et_line_r <= et_next_s;
        if (evict_done_en) begin
          evict_pend_r <= 1'b0;
        end
      end
      case (state_r)
        S_IDLE:    if (alloc_en) state_r <= S_ALLOC;
        S_ALLOC:   if (upd_en) state_r <= S_HZD;
        S_HZD: begin
          if (free_s) begin
            state_r <= need_evict_r ? S_EVICT : (need_linefill_r ? S_LF_REQ : S_REPLAY);
          end
        end
        S_EVICT:   if (evict_req_rdy) state_r <= S_CLEAN;
        S_CLEAN: begin
          if (evict_dat_ram_clean_en) begin
            state_r <= need_linefill_r ? S_LF_REQ : S_REPLAY;
          end
        end
        S_LF_REQ:  if (downstream_req_rdy) state_r <= S_LF_WAIT;
        S_LF_WAIT: begin
          if (linefill_beat_en) begin
            if (beat_cnt_r == BEAT_W'(BEATS - 1)) begin
              beat_cnt_r <= '0;
              state_r    <= S_REPLAY;
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
          end
        end
        S_REPLAY:  if (replay_exit_s) state_r <= S_IDLE;
        default:   state_r <= S_IDLE;
      endcase
    end
  end

  // Merge queue; pushes and pops never coincide since merges stop before replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SUB_NUM; i++) begin
        q_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        q_mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_l1d_mshr_entry_merge.sv
// Directed self-checking bench for l1d_mshr_entry_merge with default parameters.
module tb_l1d_mshr_entry_merge;

  localparam int UPD_W = 6 + 2 + 40 + 4 + 4 + 64 + 8 + 16;
  localparam int MRG_W = 1 + 4 + 64 + 8;
  localparam int DAT_W = 1 + 6 + 2 + 4 + 64 + 8 + 1;

  logic clk, rst;
  logic alloc_vld, alloc_en, upd_en;
  logic [UPD_W-1:0] upd_pld;
  logic merge_vld, merge_rdy;
  logic [MRG_W-1:0] merge_pld;
  logic [7:0] v_release_iw_in, v_release_et_in;
  logic evict_req_vld, evict_req_rdy;
  logic [7:0] evict_req_pld;
  logic evict_dat_ram_clean_en, evict_done_en;
  logic downstream_req_vld, downstream_req_rdy;
  logic [27:0] downstream_req_pld;
  logic linefill_beat_en;
  logic dat_ram_req_vld, dat_ram_req_rdy;
  logic [DAT_W-1:0] dat_ram_req_pld;
  logic [5:0] hzd_index;
  logic [1:0] hzd_way;
  logic [19:0] hzd_evict_tag;
  logic hzd_iw_en, hzd_et_en, release_iw_en, release_et_en;

  int pass_cnt = 0;
  int total_cnt = 0;

  l1d_mshr_entry_merge dut (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld), .alloc_en(alloc_en),
    .upd_en(upd_en), .upd_pld(upd_pld), .merge_vld(merge_vld), .merge_rdy(merge_rdy),
    .merge_pld(merge_pld), .v_release_iw_in(v_release_iw_in), .v_release_et_in(v_release_et_in),
    .evict_req_vld(evict_req_vld), .evict_req_rdy(evict_req_rdy), .evict_req_pld(evict_req_pld),
    .evict_dat_ram_clean_en(evict_dat_ram_clean_en), .evict_done_en(evict_done_en),
    .downstream_req_vld(downstream_req_vld), .downstream_req_rdy(downstream_req_rdy),
    .downstream_req_pld(downstream_req_pld), .linefill_beat_en(linefill_beat_en),
    .dat_ram_req_vld(dat_ram_req_vld), .dat_ram_req_rdy(dat_ram_req_rdy),
    .dat_ram_req_pld(dat_ram_req_pld), .hzd_index(hzd_index), .hzd_way(hzd_way),
    .hzd_evict_tag(hzd_evict_tag), .hzd_iw_en(hzd_iw_en), .hzd_et_en(hzd_et_en),
    .release_iw_en(release_iw_en), .release_et_en(release_et_en)
  );

  always #5 clk = ~clk;

  function automatic logic [UPD_W-1:0] mk_upd(
    input logic [5:0] idx, input logic [1:0] way, input logic [19:0] ntag, input logic [19:0] etag,
    input logic ne, input logic nl, input logic nrw, input logic rw, input logic [3:0] off,
    input logic [63:0] wd, input logic [7:0] be, input logic [7:0] iw, input logic [7:0] et);
    mk_upd = {idx, way, ntag, etag, ne, nl, nrw, rw, off, wd, be, iw, et};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_beats(input int n);
    for (int i = 0; i < n; i++) begin
      linefill_beat_en = 1'b1;
      tick();
    end
    linefill_beat_en = 1'b0;
  endtask

  task automatic alloc_upd(input logic [UPD_W-1:0] u);
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    upd_en = 1'b1;
    upd_pld = u;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [DAT_W+89:0] others;
    rst = 1'b1;
    tick();
    others = {merge_rdy, evict_req_vld, evict_req_pld, downstream_req_vld, downstream_req_pld,
              dat_ram_req_vld, dat_ram_req_pld, hzd_index, hzd_way, hzd_evict_tag,
              hzd_iw_en, hzd_et_en, release_iw_en, release_et_en};
    total_cnt++;
    if (alloc_vld !== 1'b1) $display("FAIL reset_alloc_vld: got %b expected 1", alloc_vld);
    else pass_cnt++;
    total_cnt++;
    if (others !== '0) $display("FAIL reset_outputs: got %h expected 0", others);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_miss();
    logic [DAT_W-1:0] exp_dat;
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    total_cnt++;
    if (alloc_vld !== 1'b0) $display("FAIL clean_alloc_drop: got %b expected 0", alloc_vld);
    else pass_cnt++;
    upd_en = 1'b1;
    upd_pld = mk_upd(6'h2A, 2'd1, 20'hABCDE, 20'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5,
                     64'hDEAD_BEEF_0123_4567, 8'hFF, 8'h00, 8'h00);
    tick();
    upd_en = 1'b0;
    total_cnt++;
    if ({downstream_req_vld, hzd_iw_en, hzd_index} !== {1'b0, 1'b1, 6'h2A})
      $display("FAIL clean_hzd: got %h expected %h", {downstream_req_vld, hzd_iw_en, hzd_index}, {1'b0, 1'b1, 6'h2A});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({downstream_req_vld, downstream_req_pld} !== {1'b1, 6'h2A, 2'd1, 20'hABCDE})
      $display("FAIL clean_lf_req: got %h expected %h", {downstream_req_vld, downstream_req_pld}, {1'b1, 6'h2A, 2'd1, 20'hABCDE});
    else pass_cnt++;
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(3);
    total_cnt++;
    if (dat_ram_req_vld !== 1'b0) $display("FAIL clean_3_beats: got %b expected 0", dat_ram_req_vld);
    else pass_cnt++;
    fill_beats(1);
    exp_dat = {1'b1, 6'h2A, 2'd1, 4'h5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0};
    total_cnt++;
    if ({dat_ram_req_vld, dat_ram_req_pld} !== {1'b1, exp_dat})
      $display("FAIL clean_replay_pld: got %h expected %h", {dat_ram_req_vld, dat_ram_req_pld}, {1'b1, exp_dat});
    else pass_cnt++;
    dat_ram_req_rdy = 1'b1;
    tick();
    dat_ram_req_rdy = 1'b0;
    total_cnt++;
    if ({alloc_vld, release_iw_en, dat_ram_req_vld, hzd_iw_en} !== 4'b1100)
      $display("FAIL clean_idle_release: got %b expected 1100", {alloc_vld, release_iw_en, dat_ram_req_vld, hzd_iw_en});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (release_iw_en !== 1'b0) $display("FAIL clean_release_once: got %b expected 0", release_iw_en);
    else pass_cnt++;
  endtask

  task automatic test_dirty_miss();
    logic [DAT_W-1:0] exp_dat;
    alloc_upd(mk_upd(6'h05, 2'd3, 20'h0F0F0, 20'h7777A, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9,
                     64'h55, 8'hF0, 8'h00, 8'h00));
    total_cnt++;
    if ({hzd_et_en, hzd_evict_tag} !== {1'b1, 20'h7777A})
      $display("FAIL dirty_et: got %h expected %h", {hzd_et_en, hzd_evict_tag}, {1'b1, 20'h7777A});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({evict_req_vld, evict_req_pld, downstream_req_vld} !== {1'b1, 6'h05, 2'd3, 1'b0})
      $display("FAIL dirty_evict_req: got %h expected %h", {evict_req_vld, evict_req_pld, downstream_req_vld}, {1'b1, 6'h05, 2'd3, 1'b0});
    else pass_cnt++;
    evict_req_rdy = 1'b1;
    tick();
    evict_req_rdy = 1'b0;
    tick();
    total_cnt++;
    if ({evict_req_vld, downstream_req_vld} !== 2'b00)
      $display("FAIL dirty_clean_wait: got %b expected 00", {evict_req_vld, downstream_req_vld});
    else pass_cnt++;
    evict_dat_ram_clean_en = 1'b1;
    tick();
    evict_dat_ram_clean_en = 1'b0;
    total_cnt++;
    if (downstream_req_vld !== 1'b1) $display("FAIL dirty_lf_after_clean: got %b expected 1", downstream_req_vld);
    else pass_cnt++;
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(4);
    exp_dat = {1'b1, 6'h05, 2'd3, 4'h9, 64'h55, 8'hF0, 1'b1};
    total_cnt++;
    if ({dat_ram_req_vld, dat_ram_req_pld} !== {1'b1, exp_dat})
      $display("FAIL dirty_part: got %h expected %h", {dat_ram_req_vld, dat_ram_req_pld}, {1'b1, exp_dat});
    else pass_cnt++;
    dat_ram_req_rdy = 1'b1;
    tick();
    dat_ram_req_rdy = 1'b0;
    total_cnt++;
    if ({alloc_vld, dat_ram_req_vld} !== 2'b00)
      $display("FAIL dirty_wait_done: got %b expected 00", {alloc_vld, dat_ram_req_vld});
    else pass_cnt++;
    evict_done_en = 1'b1;
    tick();
    evict_done_en = 1'b0;
    total_cnt++;
    if ({alloc_vld, release_et_en, hzd_et_en} !== 3'b010)
      $display("FAIL dirty_release_et: got %b expected 010", {alloc_vld, release_et_en, hzd_et_en});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({alloc_vld, release_iw_en, release_et_en} !== 3'b110)
      $display("FAIL dirty_idle: got %b expected 110", {alloc_vld, release_iw_en, release_et_en});
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    upd_en = 1'b1;
    upd_pld = mk_upd(6'h10, 2'd0, 20'h00321, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,
                     64'h0, 8'h00, 8'b0000_0100, 8'h00);
    v_release_iw_in = 8'b0000_0100;
    tick();
    upd_en = 1'b0;
    v_release_iw_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({evict_req_vld, downstream_req_vld} !== 2'b00)
        $display("FAIL hzd_blocked_%0d: got %b expected 00", i, {evict_req_vld, downstream_req_vld});
      else pass_cnt++;
      tick();
    end
    v_release_iw_in = 8'b0000_0100;
    tick();
    v_release_iw_in = 8'h00;
    total_cnt++;
    if (downstream_req_vld !== 1'b1) $display("FAIL hzd_released: got %b expected 1", downstream_req_vld);
    else pass_cnt++;
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(4);
    total_cnt++;
    if (dat_ram_req_vld !== 1'b0) $display("FAIL hzd_empty_replay: got %b expected 0", dat_ram_req_vld);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({alloc_vld, release_iw_en} !== 2'b11)
      $display("FAIL hzd_idle: got %b expected 11", {alloc_vld, release_iw_en});
    else pass_cnt++;
  endtask

  task automatic test_merge();
    logic [DAT_W-1:0] exp_dat;
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    upd_en = 1'b1;
    upd_pld = mk_upd(6'h11, 2'd2, 20'h12345, 20'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0,
                     64'hA0, 8'hFF, 8'h00, 8'h00);
    merge_vld = 1'b1;
    merge_pld = {1'b1, 4'h1, 64'hA1, 8'hFF};
    total_cnt++;
    if (merge_rdy !== 1'b0) $display("FAIL merge_refused_alloc: got %b expected 0", merge_rdy);
    else pass_cnt++;
    tick();
    upd_en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      merge_pld = {1'b1, i[3:0], 64'hA0 + 64'(i), 8'hFF};
      total_cnt++;
      if (merge_rdy !== 1'b1) $display("FAIL merge_accept_%0d: got %b expected 1", i, merge_rdy);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (merge_rdy !== 1'b0) $display("FAIL merge_full: got %b expected 0", merge_rdy);
    else pass_cnt++;
    merge_vld = 1'b0;
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(4);
    for (int i = 0; i < 4; i++) begin
      exp_dat = {1'b1, 6'h11, 2'd2, i[3:0], 64'hA0 + 64'(i), 8'hFF, 1'b0};
      total_cnt++;
      if ({dat_ram_req_vld, dat_ram_req_pld} !== {1'b1, exp_dat})
        $display("FAIL merge_replay_%0d: got %h expected %h", i, {dat_ram_req_vld, dat_ram_req_pld}, {1'b1, exp_dat});
      else pass_cnt++;
      dat_ram_req_rdy = 1'b1;
      tick();
      dat_ram_req_rdy = 1'b0;
      if (i < 3) tick();
    end
    total_cnt++;
    if ({alloc_vld, release_iw_en} !== 2'b11)
      $display("FAIL merge_idle: got %b expected 11", {alloc_vld, release_iw_en});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_lf();
    logic [UPD_W-1:0] u;
    logic [DAT_W+89:0] others;
    u = mk_upd(6'h3C, 2'd1, 20'h55555, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2,
               64'h0, 8'hFF, 8'h00, 8'h00);
    alloc_upd(u);
    tick();
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(2);
    #2;
    rst = 1'b1;
    #1;
    others = {merge_rdy, evict_req_vld, evict_req_pld, downstream_req_vld, downstream_req_pld,
              dat_ram_req_vld, dat_ram_req_pld, hzd_index, hzd_way, hzd_evict_tag,
              hzd_iw_en, hzd_et_en, release_iw_en, release_et_en};
    total_cnt++;
    if ({alloc_vld, others} !== {1'b1, {(DAT_W+90){1'b0}}})
      $display("FAIL midlf_reset: got %h expected %h", {alloc_vld, others}, {1'b1, {(DAT_W+90){1'b0}}});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    alloc_upd(u);
    tick();
    downstream_req_rdy = 1'b1;
    tick();
    downstream_req_rdy = 1'b0;
    fill_beats(3);
    total_cnt++;
    if (dat_ram_req_vld !== 1'b0) $display("FAIL midlf_beats_restart: got %b expected 0", dat_ram_req_vld);
    else pass_cnt++;
    fill_beats(1);
    total_cnt++;
    if (dat_ram_req_vld !== 1'b1) $display("FAIL midlf_full_fill: got %b expected 1", dat_ram_req_vld);
    else pass_cnt++;
    dat_ram_req_rdy = 1'b1;
    tick();
    dat_ram_req_rdy = 1'b0;
    total_cnt++;
    if (alloc_vld !== 1'b1) $display("FAIL midlf_idle: got %b expected 1", alloc_vld);
    else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    alloc_en = 1'b0;
    upd_en = 1'b0;
    upd_pld = '0;
    merge_vld = 1'b0;
    merge_pld = '0;
    v_release_iw_in = 8'h00;
    v_release_et_in = 8'h00;
    evict_req_rdy = 1'b0;
    evict_dat_ram_clean_en = 1'b0;
    evict_done_en = 1'b0;
    downstream_req_rdy = 1'b0;
    linefill_beat_en = 1'b0;
    dat_ram_req_rdy = 1'b0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_hazard();
    test_merge();
    test_reset_mid_lf();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
